// File: rtl/pipeline_control_unit.sv
// Pipeline sequencer for the five-stage MIPS datapath: latch enables, bubble flushes, PC update,
// halt tracking, data-memory wait supervision and stall/flush performance counters.
module pipeline_control_unit #(
  parameter int unsigned WAIT_LIMIT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       decode_rs,
  input  logic [4:0]       decode_rt,
  input  logic             decode_uses_rt,
  input  logic             execute_mem_to_reg,
  input  logic [4:0]       execute_reg_wr_addr,
  input  logic             memory_dmemREN,
  input  logic             memory_dmemWEN,
  input  logic             memory_branch_taken,
  input  logic             memory_jump,
  input  logic             write_back_halt,
  output logic             pc_en,
  output logic             fetch_decode_en,
  output logic             decode_execute_en,
  output logic             execute_memory_en,
  output logic             memory_write_back_en,
  output logic             fetch_decode_flush,
  output logic             decode_execute_flush,
  output logic             execute_memory_flush,
  output logic             halt,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WaitW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(WAIT_LIMIT);

  typedef enum logic [1:0] {StRun, StMemWait, StHalted} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, flush_count_q;

  logic load_use;
  logic dmem_miss;
  logic transfer;

  assign load_use = execute_mem_to_reg && (execute_reg_wr_addr != 5'd0) &&
                    ((execute_reg_wr_addr == decode_rs) ||
                     (decode_uses_rt && (execute_reg_wr_addr == decode_rt)));
  assign dmem_miss = (memory_dmemREN || memory_dmemWEN) && !dhit;
  assign transfer  = memory_branch_taken || memory_jump;

  always_comb begin
    state_d              = state_q;
    wait_cnt_d           = wait_cnt_q;
    pc_en                = 1'b0;
    fetch_decode_en      = 1'b0;
    decode_execute_en    = 1'b0;
    execute_memory_en    = 1'b0;
    memory_write_back_en = 1'b0;
    fetch_decode_flush   = 1'b0;
    decode_execute_flush = 1'b0;
    execute_memory_flush = 1'b0;
    halt                 = 1'b0;

    // Outputs stay quiet while reset is held, regardless of the inputs.
    if (nRST) begin
      unique case (state_q)
        StHalted: halt = 1'b1;
        StMemWait, StRun: begin
          if (state_q == StMemWait && !dhit) begin
            if (wait_cnt_q < WaitMax) wait_cnt_d = wait_cnt_q + WaitW'(1);
          end else if (write_back_halt) begin
            halt    = 1'b1;
            state_d = StHalted;
          end else if (state_q == StRun && dmem_miss) begin
            state_d    = StMemWait;
            wait_cnt_d = WaitW'(1);
          end else begin
            state_d              = StRun;
            pc_en                = 1'b1;
            fetch_decode_en      = 1'b1;
            decode_execute_en    = 1'b1;
            execute_memory_en    = 1'b1;
            memory_write_back_en = 1'b1;
            if (transfer) begin
              fetch_decode_flush   = 1'b1;
              decode_execute_flush = 1'b1;
              execute_memory_flush = 1'b1;
            end else if (load_use) begin
              // Hold PC and IF/ID, inject one bubble into ID/EX.
              pc_en                = 1'b0;
              fetch_decode_en      = 1'b0;
              decode_execute_flush = 1'b1;
            end else if (!ihit) begin
              pc_en              = 1'b0;
              fetch_decode_flush = 1'b1;
            end
          end
        end
        default: state_d = StRun;
      endcase
    end

    mem_timeout_d = mem_timeout_q || (wait_cnt_d == WaitMax);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      // The cycle that first sees the halt is not a stall.
      if (!pc_en && !halt) stall_count_q <= stall_count_q + CNT_W'(1);
      if (fetch_decode_flush || decode_execute_flush || execute_memory_flush) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit with a short wait limit so the timeout is reachable.
module tb_pipeline_control_unit;

  localparam int unsigned WaitLimit = 4;
  localparam int unsigned CntW      = 16;

  logic            CLK = 1'b0;
  logic            nRST;
  logic            ihit, dhit;
  logic [4:0]      decode_rs, decode_rt, execute_reg_wr_addr;
  logic            decode_uses_rt, execute_mem_to_reg;
  logic            memory_dmemREN, memory_dmemWEN, memory_branch_taken, memory_jump;
  logic            write_back_halt;
  logic            pc_en, fetch_decode_en, decode_execute_en, execute_memory_en;
  logic            memory_write_back_en;
  logic            fetch_decode_flush, decode_execute_flush, execute_memory_flush;
  logic            halt, mem_timeout;
  logic [CntW-1:0] stall_count, flush_count;

  int tests  = 0;
  int failed = 0;

  pipeline_control_unit #(
    .WAIT_LIMIT(WaitLimit),
    .CNT_W     (CntW)
  ) dut (
    .CLK                 (CLK),
    .nRST                (nRST),
    .ihit                (ihit),
    .dhit                (dhit),
    .decode_rs           (decode_rs),
    .decode_rt           (decode_rt),
    .decode_uses_rt      (decode_uses_rt),
    .execute_mem_to_reg  (execute_mem_to_reg),
    .execute_reg_wr_addr (execute_reg_wr_addr),
    .memory_dmemREN      (memory_dmemREN),
    .memory_dmemWEN      (memory_dmemWEN),
    .memory_branch_taken (memory_branch_taken),
    .memory_jump         (memory_jump),
    .write_back_halt     (write_back_halt),
    .pc_en               (pc_en),
    .fetch_decode_en     (fetch_decode_en),
    .decode_execute_en   (decode_execute_en),
    .execute_memory_en   (execute_memory_en),
    .memory_write_back_en(memory_write_back_en),
    .fetch_decode_flush  (fetch_decode_flush),
    .decode_execute_flush(decode_execute_flush),
    .execute_memory_flush(execute_memory_flush),
    .halt                (halt),
    .mem_timeout         (mem_timeout),
    .stall_count         (stall_count),
    .flush_count         (flush_count)
  );

  always #5 CLK = ~CLK;

  // {pc, fd, de, em, mw} enables and {fd, de, em} flushes
  logic [4:0] en;
  logic [2:0] fl;
  assign en = {pc_en, fetch_decode_en, decode_execute_en, execute_memory_en, memory_write_back_en};
  assign fl = {fetch_decode_flush, decode_execute_flush, execute_memory_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ihit = 1'b1; dhit = 1'b0;
    decode_rs = 5'd0; decode_rt = 5'd0; decode_uses_rt = 1'b0;
    execute_mem_to_reg = 1'b0; execute_reg_wr_addr = 5'd0;
    memory_dmemREN = 1'b0; memory_dmemWEN = 1'b0;
    memory_branch_taken = 1'b0; memory_jump = 1'b0; write_back_halt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_en", 32'(en), 32'h0);
    chk("reset_fl", 32'(fl), 32'h0);
    chk("reset_halt", 32'(halt), 32'h0);
    chk("reset_stall", 32'(stall_count), 32'h0);
    chk("reset_timeout", 32'(mem_timeout), 32'h0);

    nRST = 1'b1;
    #1;
    chk("run_en", 32'(en), 32'h1f);
    chk("run_fl", 32'(fl), 32'h0);
    tick();
    chk("run_stall", 32'(stall_count), 32'h0);

    // Load-use on rs
    execute_mem_to_reg = 1'b1; execute_reg_wr_addr = 5'd5; decode_rs = 5'd5;
    #1;
    chk("lu_en", 32'(en), 32'h07);
    chk("lu_fl", 32'(fl), 32'h2);
    tick();
    chk("lu_stall", 32'(stall_count), 32'h1);
    chk("lu_flush", 32'(flush_count), 32'h1);
    execute_mem_to_reg = 1'b0;
    #1;
    chk("lu_clear_en", 32'(en), 32'h1f);

    // rt match only counts when the instruction reads rt
    execute_mem_to_reg = 1'b1; decode_rs = 5'd3; decode_rt = 5'd5;
    #1;
    chk("lu_rt_unused", 32'(en), 32'h1f);
    decode_uses_rt = 1'b1;
    #1;
    chk("lu_rt_used", 32'(en), 32'h07);
    decode_uses_rt = 1'b0; execute_reg_wr_addr = 5'd0; decode_rs = 5'd0;
    #1;
    chk("lu_zero_reg", 32'(en), 32'h1f);

    // Branch beats load-use and a fetch miss
    execute_reg_wr_addr = 5'd5; decode_rs = 5'd5; memory_branch_taken = 1'b1; ihit = 1'b0;
    #1;
    chk("br_en", 32'(en), 32'h1f);
    chk("br_fl", 32'(fl), 32'h7);
    tick();
    chk("br_flush", 32'(flush_count), 32'h2);
    chk("br_stall", 32'(stall_count), 32'h1);

    // Instruction fetch miss
    clear_inputs();
    ihit = 1'b0;
    #1;
    chk("imiss_en", 32'(en), 32'h0f);
    chk("imiss_fl", 32'(fl), 32'h4);
    tick();
    chk("imiss_stall", 32'(stall_count), 32'h2);
    chk("imiss_flush", 32'(flush_count), 32'h3);

    // Data wait: three cycles with dhit low
    ihit = 1'b1; memory_dmemREN = 1'b1;
    #1;
    chk("dw_entry_en", 32'(en), 32'h0);
    tick();
    chk("dw_wait_en", 32'(en), 32'h0);
    tick();
    tick();
    chk("dw_stall", 32'(stall_count), 32'h5);
    chk("dw_no_timeout", 32'(mem_timeout), 32'h0);
    dhit = 1'b1;
    #1;
    chk("dw_done_en", 32'(en), 32'h1f);
    tick();
    chk("dw_after_stall", 32'(stall_count), 32'h5);
    dhit = 1'b0; memory_dmemREN = 1'b0;
    #1;
    chk("dw_back_run", 32'(en), 32'h1f);

    // Timeout: six wait cycles against a limit of four
    memory_dmemWEN = 1'b1;
    repeat (3) tick();
    chk("to_before", 32'(mem_timeout), 32'h0);
    tick();
    chk("to_set", 32'(mem_timeout), 32'h1);
    repeat (2) tick();
    chk("to_stall", 32'(stall_count), 32'hb);
    dhit = 1'b1;
    #1;
    chk("to_done_en", 32'(en), 32'h1f);
    tick();
    dhit = 1'b0; memory_dmemWEN = 1'b0;
    #1;
    chk("to_sticky", 32'(mem_timeout), 32'h1);

    // Halt wins over a pending data miss and is absorbing
    write_back_halt = 1'b1; memory_dmemREN = 1'b1;
    #1;
    chk("halt_first", 32'(halt), 32'h1);
    chk("halt_first_en", 32'(en), 32'h0);
    tick();
    clear_inputs();
    memory_branch_taken = 1'b1;
    #1;
    chk("halted", 32'(halt), 32'h1);
    chk("halted_en", 32'(en), 32'h0);
    chk("halted_fl", 32'(fl), 32'h0);
    repeat (3) tick();
    chk("halted_stall", 32'(stall_count), 32'hb);
    chk("halted_flush", 32'(flush_count), 32'h3);

    // Reset pulse out of HALTED
    clear_inputs();
    nRST = 1'b0;
    #1;
    chk("rst_halt", 32'(halt), 32'h0);
    chk("rst_stall", 32'(stall_count), 32'h0);
    chk("rst_flush", 32'(flush_count), 32'h0);
    chk("rst_timeout", 32'(mem_timeout), 32'h0);
    chk("rst_en", 32'(en), 32'h0);
    tick();
    nRST = 1'b1;
    #1;
    chk("rerun_en", 32'(en), 32'h1f);
    chk("rerun_halt", 32'(halt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
